// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: two-requester SPI mode-0 master with bus arbitration; define SPI_ARB_ROUNDROBIN_EN for round-robin tie-break
module spi_bus_arbiter #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_start,
  input  logic [7:0] a_tx,
  output logic [7:0] a_rx,
  output logic       a_gnt,
  output logic       a_busy,
  input  logic       b_req,
  input  logic       b_start,
  input  logic [7:0] b_tx,
  output logic [7:0] b_rx,
  output logic       b_gnt,
  output logic       b_busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs0_n,
  output logic       cs1_n
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} arb_t;
  typedef enum logic {ENG_IDLE, ENG_SHIFT} eng_t;
  arb_t arb_q, arb_d;
  eng_t eng_q, eng_d;
  logic       sclk_q, sclk_d;
  logic [3:0] div_q, div_d, half_q, half_d;
  logic [7:0] sh_q, sh_d, in_q, in_d, a_rx_q, a_rx_d, b_rx_q, b_rx_d;
  logic       own_a, own_b, tick, done, go, pick_b;
  assign own_a = arb_q == OWN_A;
  assign own_b = arb_q == OWN_B;
  assign tick  = eng_q == ENG_SHIFT && div_q == 4'(DIV - 1);
  assign done  = tick && half_q == 4'd15;
  assign go    = ((own_a && a_req && a_start) || (own_b && b_req && b_start)) && (eng_q == ENG_IDLE || done);
`ifdef SPI_ARB_ROUNDROBIN_EN
  logic last_q, last_d;
  assign pick_b = ~last_q;
  // Remember who was granted last (1 = B) so a tie goes to the other requester
  always_comb last_d = (arb_q == IDLE && arb_d != IDLE) ? (arb_d == OWN_B) : last_q;
  // Last-served flag register; reset points at B so A wins the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
`else
  assign pick_b = 1'b0;
`endif
  // Ownership: grant from IDLE, hold while req is high, release only once the engine is idle
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      IDLE:    arb_d = (a_req && b_req) ? (pick_b ? OWN_B : OWN_A) : a_req ? OWN_A : b_req ? OWN_B : IDLE;
      OWN_A:   arb_d = (!a_req && eng_q == ENG_IDLE) ? IDLE : OWN_A;
      OWN_B:   arb_d = (!b_req && eng_q == ENG_IDLE) ? IDLE : OWN_B;
      default: arb_d = IDLE;
    endcase
  end
  // Shift engine: 16 half-periods of DIV cycles, sample miso entering odd halves, shift mosi leaving them
  always_comb begin
    eng_d  = go ? ENG_SHIFT : done ? ENG_IDLE : eng_q;
    div_d  = (go || tick || eng_q == ENG_IDLE) ? 4'd0 : div_q + 4'd1;
    half_d = (go || eng_q == ENG_IDLE) ? 4'd0 : tick ? half_q + 4'd1 : half_q;
    sclk_d = (go || eng_q == ENG_IDLE) ? 1'b0 : tick ? ~half_q[0] : sclk_q;
    sh_d   = go ? (own_a ? a_tx : b_tx) : (tick && half_q[0]) ? {sh_q[6:0], 1'b1} : sh_q;
    in_d   = (tick && !half_q[0]) ? {in_q[6:0], miso} : in_q;
    a_rx_d = (done && own_a) ? in_q : a_rx_q;
    b_rx_d = (done && own_b) ? in_q : b_rx_q;
  end
  // State registers; reset aborts any byte in flight without touching the rx bytes beyond their reset value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arb_q  <= IDLE;
      eng_q  <= ENG_IDLE;
      sclk_q <= 1'b0;
      div_q  <= 4'd0;
      half_q <= 4'd0;
      sh_q   <= 8'hFF;
      in_q   <= 8'h00;
      a_rx_q <= 8'hFF;
      b_rx_q <= 8'hFF;
    end else begin
      arb_q  <= arb_d;
      eng_q  <= eng_d;
      sclk_q <= sclk_d;
      div_q  <= div_d;
      half_q <= half_d;
      sh_q   <= sh_d;
      in_q   <= in_d;
      a_rx_q <= a_rx_d;
      b_rx_q <= b_rx_d;
    end
  assign a_gnt  = own_a;
  assign b_gnt  = own_b;
  assign cs0_n  = ~own_a;
  assign cs1_n  = ~own_b;
  assign a_busy = own_a && eng_q == ENG_SHIFT;
  assign b_busy = own_b && eng_q == ENG_SHIFT;
  assign a_rx   = a_rx_q;
  assign b_rx   = b_rx_q;
  assign sclk   = sclk_q;
  assign mosi   = eng_q == ENG_SHIFT ? sh_q[7] : 1'b1;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: randomized bytes and arbitration scenarios checked against a transaction-level model
module tb_spi_bus_arbiter;
  localparam int D = 3;
  logic clk = 1'b0, rst;
  logic a_req, a_start, b_req, b_start, miso;
  logic [7:0] a_tx, b_tx, a_rx, b_rx;
  logic a_gnt, a_busy, b_gnt, b_busy, sclk, mosi, cs0_n, cs1_n;
  int checks = 0, failures = 0;
  logic [7:0] exp_rx [2];
  bit last_b;

  spi_bus_arbiter #(.DIV(D)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_start(a_start), .a_tx(a_tx), .a_rx(a_rx), .a_gnt(a_gnt), .a_busy(a_busy),
    .b_req(b_req), .b_start(b_start), .b_tx(b_tx), .b_rx(b_rx), .b_gnt(b_gnt), .b_busy(b_busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs0_n(cs0_n), .cs1_n(cs1_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input bit w);
    return w ? b_busy : a_busy;
  endfunction

  function automatic logic [7:0] rx_of(input bit w);
    return w ? b_rx : a_rx;
  endfunction

  function automatic bit winner();
`ifdef SPI_ARB_ROUNDROBIN_EN
    return last_b ? 1'b0 : 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input bit w, input logic v);
    if (w) b_req = v; else a_req = v;
  endtask

  task automatic set_start(input bit w, input logic v, input logic [7:0] tx);
    if (w) begin b_start = v; b_tx = tx; end
    else begin a_start = v; a_tx = tx; end
  endtask

  task automatic check_gnt(input string tag, input bit w);
    check(tag, {a_gnt, b_gnt, cs0_n, cs1_n}, w ? 4'b0110 : 4'b1001);
    last_b = w;
  endtask

  // Entered at a negedge where w owns the bus; miso is driven from mb bit by bit, mosi/sclk checked per cycle
  task automatic run_byte(input bit w, input logic [7:0] tx, input logic [7:0] mb, input bit pre,
                          input bit chain, input logic [7:0] ntx, input int drop_at, input bit poke,
                          input int rst_at);
    int h, k;
    if (!pre) set_start(w, 1'b1, tx);
    for (int i = 1; i <= 16 * D; i++) begin
      @(negedge clk);
      if (i == 1) set_start(w, 1'b0, tx);
      h = (i - 1) / D;
      k = h / 2;
      if (i == 1 && pre) check("b2b_rx", rx_of(w), exp_rx[w]);
      check("shift", {busy_of(w), sclk, mosi, busy_of(!w)}, {1'b1, h[0], tx[7-k], 1'b0});
      if (poke && i == 3) begin set_start(w, 1'b1, ~tx); set_start(!w, 1'b1, 8'h3C); end
      if (poke && i == 4) begin set_start(w, 1'b0, tx); set_start(!w, 1'b0, 8'h00); end
      if (i == drop_at) set_req(w, 1'b0);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_async", {sclk, mosi, cs0_n, cs1_n, a_gnt, b_gnt, a_busy, b_busy}, 8'b01110000);
        check("rst_rx", {a_rx, b_rx}, 16'hFFFF);
        exp_rx[0] = 8'hFF;
        exp_rx[1] = 8'hFF;
        last_b = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        return;
      end
      miso = mb[7-k];
      if (chain && i == 16 * D) set_start(w, 1'b1, ntx);
    end
    exp_rx[w] = mb;
    if (!chain) begin
      @(negedge clk);
      check("done", {busy_of(w), sclk, mosi}, 3'b001);
      check("rx", rx_of(w), mb);
      check("rx_other", rx_of(!w), exp_rx[!w]);
    end
  endtask

  initial begin
    logic [7:0] t0, t1, t2, m0, m1, m2;
    bit w;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_start = 1'b0; b_start = 1'b0;
    a_tx = 8'h00; b_tx = 8'h00; miso = 1'b0;
    exp_rx[0] = 8'hFF; exp_rx[1] = 8'hFF; last_b = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", {sclk, mosi, cs0_n, cs1_n, a_gnt, b_gnt, a_busy, b_busy}, 8'b01110000);
    check("reset_rx", {a_rx, b_rx}, 16'hFFFF);
    rst = 1'b0;
    @(negedge clk);
    a_start = 1'b1; a_tx = 8'h55;
    @(negedge clk);
    a_start = 1'b0;
    check("idle_start", {a_busy, b_busy, sclk, mosi, cs0_n, cs1_n}, 6'b000111);
    a_req = 1'b1;
    @(negedge clk);
    check_gnt("gnt_a", 1'b0);
    run_byte(1'b0, 8'h96, 8'h5A, 1'b0, 1'b0, 8'h00, 0, 1'b0, 7);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst", {a_gnt, b_gnt, cs0_n, cs1_n, a_rx}, {4'b0011, 8'hFF});
    a_req = 1'b1;
    @(negedge clk);
    check_gnt("gnt_a_rst", 1'b0);
    run_byte(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0);
    t0 = 8'($urandom); t1 = 8'($urandom); t2 = 8'($urandom);
    m0 = 8'($urandom); m1 = 8'($urandom); m2 = 8'($urandom);
    run_byte(1'b0, t0, m0, 1'b0, 1'b1, t1, 0, 1'b0, 0);
    run_byte(1'b0, t1, m1, 1'b1, 1'b1, t2, 0, 1'b1, 0);
    run_byte(1'b0, t2, m2, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0);
    check("b_rx_hold", b_rx, 8'hFF);
    a_req = 1'b0;
    @(negedge clk);
    check("rel_a", {a_gnt, b_gnt, cs0_n, cs1_n}, 4'b0011);
    a_req = 1'b1;
    @(negedge clk);
    check_gnt("gnt_a2", 1'b0);
    run_byte(1'b0, 8'($urandom), 8'hFF, 1'b0, 1'b0, 8'h00, 10, 1'b0, 0);
    check("hold_drop", {a_gnt, cs0_n}, 2'b10);
    @(negedge clk);
    check("rel_drop", {a_gnt, b_gnt, cs0_n, cs1_n}, 4'b0011);
    b_req = 1'b1;
    @(negedge clk);
    check_gnt("gnt_b", 1'b1);
    run_byte(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 0, 1'b0, 0);
    b_req = 1'b0;
    @(negedge clk);
    check("rel_b", {a_gnt, b_gnt, cs0_n, cs1_n}, 4'b0011);
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    w = winner();
    check_gnt("tie", w);
    set_req(w, 1'b0);
    @(negedge clk);
    check("tie_idle", {a_gnt, b_gnt, cs0_n, cs1_n}, 4'b0011);
    @(negedge clk);
    check_gnt("tie_next", !w);
    set_req(!w, 1'b0);
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      w = winner();
      check_gnt("alt_gnt", w);
      run_byte(w, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, 0, 1'b0, 0);
      set_req(w, 1'b0);
      @(negedge clk);
      check("alt_idle", {a_gnt, b_gnt, cs0_n, cs1_n}, 4'b0011);
      set_req(w, 1'b1);
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
